// File: rtl/alu_flag_queue_pkg.sv
// ============================================================================
//  Module   : alu_flag_pkg
//  Brief    : Shared types, op codes, flag indices and op-class decode for
//             the ALU flag queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_flag_pkg;

  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_SHIFT = 2'd2
  } op_class_t;

  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;

  // Bit positions inside the 4-bit {N,V,C,Z} flag vector
  localparam int FLG_N = 3;
  localparam int FLG_V = 2;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 0;

  // Op code to datapath class; anything not ADD or AND/OR goes to the shifter
  function automatic op_class_t op_class(input logic [2:0] op);
    if (op[2:1] == 2'b00) begin
      return CLS_ADD;
    end else if ((op == OP_AND) || (op == OP_OR)) begin
      return CLS_LOGIC;
    end else begin
      return CLS_SHIFT;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_flag_queue_if.sv
// ============================================================================
//  Module   : alu_flag_queue_if
//  Brief    : Producer/consumer/status bundle for alu_flag_queue. The master
//             modport is the environment, the slave modport is the block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_flag_queue_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_y_add;
  logic [WIDTH-1:0] in_y_logic;
  logic [WIDTH-1:0] in_y_shift;
  logic             in_ca;
  logic             in_va;
  logic             in_cs;
  logic             in_flag_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_n;
  logic             out_v;
  logic             out_c;
  logic             out_z;
  logic [3:0]       stat_nvcz;
  logic             clr_sticky;
  logic             sticky_v;

  modport master (
    output in_valid, in_op, in_y_add, in_y_logic, in_y_shift,
           in_ca, in_va, in_cs, in_flag_we, out_ready, clr_sticky,
    input  in_ready, out_valid, out_y, out_n, out_v, out_c, out_z,
           stat_nvcz, sticky_v
  );

  modport slave (
    input  in_valid, in_op, in_y_add, in_y_logic, in_y_shift,
           in_ca, in_va, in_cs, in_flag_we, out_ready, clr_sticky,
    output in_ready, out_valid, out_y, out_n, out_v, out_c, out_z,
           stat_nvcz, sticky_v
  );
endinterface

`default_nettype wire

// File: rtl/alu_flag_queue_flag_fifo.sv
// ============================================================================
//  Module   : flag_fifo
//  Brief    : DEPTH-entry register FIFO for {Y,N,V,C,Z} entries. When empty
//             the output holds the most recently popped entry (0 after reset).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] data_o
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] last_q;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  // A full FIFO refuses a push even if a pop happens in the same cycle
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  // Storage, pointers, occupancy and last-popped holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (w_pop && !w_push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_flag_queue.sv
// ============================================================================
//  Module   : alu_flag_queue
//  Brief    : Registered ALU result/flag select. Picks the adder, logic or
//             shifter result by op class, computes N/V/C/Z, updates a status
//             register and queues {Y,N,V,C,Z} in a small FIFO.
//             Optional macro STICKY_OVF_EN enables the sticky overflow flop.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_flag_queue
  import alu_flag_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_flag_queue_if.slave bus
);
  localparam int DW = WIDTH + 4;

  op_class_t        w_cls;
  logic [WIDTH-1:0] w_y;
  logic             w_v;
  logic             w_c;
  logic [3:0]       w_nvcz;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_head;
  logic [3:0]       stat_q;

  // Select result and carry/overflow sources by op class
  always_comb begin
    w_cls = op_class(bus.in_op);
    w_y   = bus.in_y_shift;
    w_c   = bus.in_cs;
    w_v   = 1'b0;
    case (w_cls)
      CLS_ADD: begin
        w_y = bus.in_y_add;
        w_c = bus.in_ca;
        w_v = bus.in_va;
      end
      CLS_LOGIC: begin
        w_y = bus.in_y_logic;
        w_c = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_nvcz[FLG_N] = w_y[WIDTH-1];
  assign w_nvcz[FLG_V] = w_v;
  assign w_nvcz[FLG_C] = w_c;
  assign w_nvcz[FLG_Z] = (w_y == '0);

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign w_push        = bus.in_valid & ~w_full;
  assign w_pop         = ~w_empty & bus.out_ready;

  flag_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({w_y, w_nvcz[FLG_N], w_nvcz[FLG_V], w_nvcz[FLG_C], w_nvcz[FLG_Z]}),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_o  (w_head)
  );

  assign bus.out_y = w_head[DW-1:4];
  assign bus.out_n = w_head[3];
  assign bus.out_v = w_head[2];
  assign bus.out_c = w_head[1];
  assign bus.out_z = w_head[0];

  // Status register commits the accepted op's flags when write-enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= 4'b0000;
    end else if (w_push && bus.in_flag_we) begin
      stat_q <= w_nvcz;
    end
  end

  assign bus.stat_nvcz = stat_q;

`ifdef STICKY_OVF_EN
  logic sticky_q;

  // Sticky overflow: a qualifying set wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (w_push && bus.in_flag_we && w_v) begin
      sticky_q <= 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.sticky_v = sticky_q;
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clr_sticky;
  assign bus.sticky_v = 1'b0;
`endif

endmodule

`default_nettype wire
